// File: rtl/sp1_ram_dp.sv
// sp1_ram_dp: dual-port RAM (A read/write with byte enables, B read-only) with zero-fill clear engine
module sp1_ram_dp #(
   parameter int DW         = 32,
   parameter int AW         = 6,
   parameter int DEPTH      = 64,
   parameter bit RDW_MODE   = 1'b0,
   parameter bit CLR_ON_RST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   output logic            ready,
   input  logic            a_cs,
   input  logic            a_we,
   input  logic [DW/8-1:0] a_be,
   input  logic [AW-1:0]   a_adr,
   input  logic [DW-1:0]   a_din,
   output logic [DW-1:0]   a_dout,
   input  logic            b_cs,
   input  logic [AW-1:0]   b_adr,
   output logic [DW-1:0]   b_dout
);
   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] LIM  = (AW+1)'(DEPTH);
   typedef enum logic {CLEAR, READY} state_t;
   state_t        state;
   logic [AW:0]   cnt;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] a_old, merged;
   logic          a_in, b_in, a_wr;
   assign ready = state == READY;
   assign a_in  = {1'b0, a_adr} < LIM;
   assign b_in  = {1'b0, b_adr} < LIM;
   assign a_wr  = ready && a_cs && a_we && a_in;
   assign a_old = a_in ? mem[a_adr] : '0;
   for (genvar i = 0; i < DW/8; i++) begin : g_be
      assign merged[8*i+:8] = a_be[i] ? a_din[8*i+:8] : a_old[8*i+:8];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= CLR_ON_RST ? CLEAR : READY;
         cnt   <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + 1'b1;
         if (cnt == LAST) state <= READY;
      end else if (clr) begin
         state <= CLEAR;
         cnt   <= '0;
      end
   always_ff @(posedge clk)
      if (state == CLEAR) mem[cnt[AW-1:0]] <= '0;
      else if (a_wr) mem[a_adr] <= merged;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         a_dout <= '0;
         b_dout <= '0;
      end else if (ready) begin
         if (a_cs && !a_we) a_dout <= a_old;
         if (b_cs) b_dout <= !b_in ? '0 : (RDW_MODE && a_wr && a_adr == b_adr) ? merged : mem[b_adr];
      end
endmodule

// File: tb/tb_sp1_ram_dp.sv
// tb_sp1_ram_dp: scoreboard bench for sp1_ram_dp, two instances (64 words/old-data, 48 words/new-data)
`timescale 1ns/1ps
module tb_sp1_ram_dp;
   logic clk = 0;
   always #5 clk = ~clk;
   logic rst = 1, clr = 0, a_cs = 0, a_we = 0, b_cs = 0;
   logic [3:0] a_be = 0;
   logic [5:0] a_adr = 0, b_adr = 0;
   logic [31:0] a_din = 0;
   logic ready0, ready1;
   logic [31:0] a_dout0, b_dout0, a_dout1, b_dout1;
   sp1_ram_dp u0 (.clk(clk), .rst(rst), .clr(clr), .ready(ready0), .a_cs(a_cs), .a_we(a_we),
      .a_be(a_be), .a_adr(a_adr), .a_din(a_din), .a_dout(a_dout0), .b_cs(b_cs), .b_adr(b_adr),
      .b_dout(b_dout0));
   sp1_ram_dp #(.DEPTH(48), .RDW_MODE(1'b1)) u1 (.clk(clk), .rst(rst), .clr(clr), .ready(ready1),
      .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_adr(a_adr), .a_din(a_din), .a_dout(a_dout1),
      .b_cs(b_cs), .b_adr(b_adr), .b_dout(b_dout1));
   typedef struct {
      logic [31:0] r0, r1, a0, b0, a1, b1;
   } exp_t;
   exp_t q[$];
   int vec = 0, bad = 0;
   logic [31:0] mm [2][64];
   int dep [2] = '{64, 48};
   bit rdw [2] = '{1'b0, 1'b1};
   int rem [2] = '{0, 0};
   logic [31:0] ea [2] = '{0, 0};
   logic [31:0] eb [2] = '{0, 0};
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
      end
   endtask
   task automatic step();
      exp_t e;
      logic [31:0] old, nw;
      bit aw;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            ea[k] = 0;
            eb[k] = 0;
            rem[k] = dep[k];
         end else if (rem[k] > 0) begin
            mm[k][dep[k]-rem[k]] = 0;
            rem[k]--;
         end else begin
            old = a_adr < dep[k] ? mm[k][a_adr] : 0;
            for (int i = 0; i < 4; i++) nw[8*i+:8] = a_be[i] ? a_din[8*i+:8] : old[8*i+:8];
            aw = a_cs && a_we && a_adr < dep[k];
            if (b_cs) eb[k] = b_adr >= dep[k] ? 0 : (rdw[k] && aw && b_adr == a_adr) ? nw : mm[k][b_adr];
            if (a_cs && !a_we) ea[k] = old;
            if (aw) mm[k][a_adr] = nw;
            if (clr) rem[k] = dep[k];
         end
      end
      e.r0 = 32'(rem[0] == 0);
      e.r1 = 32'(rem[1] == 0);
      e.a0 = ea[0];
      e.b0 = eb[0];
      e.a1 = ea[1];
      e.b1 = eb[1];
      q.push_back(e);
   endtask
   task automatic tick();
      step();
      @(negedge clk);
   endtask
   task automatic idle();
      a_cs = 0; a_we = 0; b_cs = 0; clr = 0;
   endtask
   task automatic wr(input logic [5:0] adr, input logic [31:0] din, input logic [3:0] be);
      idle();
      a_cs = 1; a_we = 1; a_adr = adr; a_din = din; a_be = be;
      tick();
   endtask
   task automatic rd(input logic [5:0] aa, input logic [5:0] ba);
      idle();
      a_cs = 1; a_adr = aa; b_cs = 1; b_adr = ba;
      tick();
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_ready0", 32'(ready0), e.r0);
            chk("sb_ready1", 32'(ready1), e.r1);
            chk("sb_a_dout0", a_dout0, e.a0);
            chk("sb_b_dout0", b_dout0, e.b0);
            chk("sb_a_dout1", a_dout1, e.a1);
            chk("sb_b_dout1", b_dout1, e.b1);
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, vectors %0d", vec);
      $fatal(1, "timeout");
   end
   initial begin
      @(negedge clk);
      rst = 0;
      repeat (3) tick();
      rst = 1;
      repeat (63) tick();
      chk("clear_len_busy", 32'(ready0), 0);
      tick();
      chk("clear_len_done", 32'(ready0), 1);
      for (int i = 0; i < 64; i++) begin
         rd(6'(i), 6'(63 - i));
         chk("init_zero_a", a_dout0, 0);
         chk("init_zero_b", b_dout0, 0);
      end
      wr(6'h05, 32'hDEADBEEF, 4'b1111);
      chk("wr_hold_a", a_dout0, 0);
      wr(6'h05, 32'h11223344, 4'b0101);
      chk("wr_hold_a2", a_dout0, 0);
      rd(6'h05, 6'h00);
      chk("byte_en_a0", a_dout0, 32'hDE22BE44);
      chk("byte_en_a1", a_dout1, 32'hDE22BE44);
      wr(6'h0A, 32'h12345678, 4'b1111);
      idle();
      a_cs = 1; a_we = 1; a_adr = 6'h0A; a_din = 32'hCAFEF00D; a_be = 4'b1111;
      b_cs = 1; b_adr = 6'h0A;
      tick();
      chk("rdw_old", b_dout0, 32'h12345678);
      chk("rdw_new", b_dout1, 32'hCAFEF00D);
      idle();
      b_cs = 1; b_adr = 6'h0A;
      tick();
      chk("rdw_after0", b_dout0, 32'hCAFEF00D);
      chk("rdw_after1", b_dout1, 32'hCAFEF00D);
      idle();
      clr = 1; a_cs = 1; a_we = 1; a_adr = 6'h03; a_din = 32'h77777777; a_be = 4'b1111;
      tick();
      chk("clr_drop_ready", 32'(ready0), 0);
      for (int t = 0; t < 63; t++) begin
         clr = t == 9;
         b_cs = 1; b_adr = 6'($urandom_range(0, 63));
         a_cs = t < 40; a_we = 1; a_adr = 6'($urandom_range(0, 63)); a_din = $urandom; a_be = 4'hF;
         tick();
      end
      chk("clr_len_busy", 32'(ready0), 0);
      idle();
      tick();
      chk("clr_len_done", 32'(ready0), 1);
      for (int i = 0; i < 64; i++) begin
         rd(6'(i), 6'(i));
         chk("clr_zero_a", a_dout0, 0);
         chk("clr_zero_b", b_dout0, 0);
      end
      wr(6'h30, 32'hFFFFFFFF, 4'b1111);
      rd(6'h30, 6'h2F);
      chk("oor_read1", a_dout1, 0);
      chk("oor_neighbour1", b_dout1, 0);
      chk("inrange_read0", a_dout0, 32'hFFFFFFFF);
      wr(6'h07, 32'hA5A5A5A5, 4'b1111);
      rd(6'h07, 6'h07);
      chk("pre_rst_a", a_dout0, 32'hA5A5A5A5);
      idle();
      clr = 1;
      tick();
      clr = 0;
      repeat (20) tick();
      rst = 0;
      #1;
      chk("rst_a0", a_dout0, 0);
      chk("rst_b0", b_dout0, 0);
      chk("rst_a1", a_dout1, 0);
      chk("rst_b1", b_dout1, 0);
      tick();
      rst = 1;
      repeat (63) tick();
      chk("rst_clear_busy", 32'(ready0), 0);
      tick();
      chk("rst_clear_done", 32'(ready0), 1);
      repeat (1500) begin
         rst = $urandom_range(0, 599) != 0;
         clr = $urandom_range(0, 149) == 0;
         a_cs = $urandom_range(0, 3) != 0;
         a_we = 1'($urandom);
         a_be = 4'($urandom);
         a_adr = 6'($urandom_range(0, 63));
         a_din = $urandom;
         b_cs = $urandom_range(0, 3) != 0;
         b_adr = $urandom_range(0, 3) == 0 ? a_adr : 6'($urandom_range(0, 63));
         tick();
      end
      rst = 1;
      idle();
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/sp1_ram_dp.md
Name: sp1_ram_dp

Overview:
Parametrised dual-port successor to the single-port 64x32 RAM, sp1_ram, used by the stgpm core for heap/stack storage. Port A is read/write with byte enables. Port B is read-only, for a second consumer such as the GC scanner or debug. A built-in clear engine zero-fills the array after reset or on request. The block reports `ready` only when the array is usable.

Parameters:
DW, 32, data width in bits; must be a multiple of 8
AW, 6, address width
DEPTH, 64, number of words; must satisfy 1 <= DEPTH <= 2**AW
RDW_MODE, 0, read-during-write behaviour of port B when reading the address port A writes: 0 = old data, 1 = new (merged) data
CLR_ON_RST, 1, 1 = run the clear sequence after reset; 0 = ready immediately, contents undefined

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  reset, asynchronous assert, active-low
clr  in  1  single-cycle request to zero-fill the whole array
ready  out  1  1 = array accessible; 0 = clear in progress
a_cs  in  1  port A select
a_we  in  1  port A write enable; meaningful only when a_cs=1
a_be  in  DW/8  port A byte enables; bit i covers data bits [8i+7:8i]
a_adr  in  AW  port A address
a_din  in  DW  port A write data
a_dout  out  DW  port A read data, registered
b_cs  in  1  port B select (read)
b_adr  in  AW  port B address
b_dout  out  DW  port B read data, registered

Behaviour:
- Reset (rst=0, asynchronous):
  - a_dout=0, b_dout=0.
  - Clear counter=0.
  - With CLR_ON_RST=1: state=CLEAR, ready=0. With CLR_ON_RST=0: state=READY, ready=1.
  - Array contents are not reset asynchronously.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[cnt], then cnt increments. At cnt=DEPTH-1 the write happens and the next state is READY.
  - The clear takes exactly DEPTH cycles. ready rises on the edge after the last clear write.
  - READY goes to CLEAR on any edge that samples clr=1. cnt reloads to 0 and ready drops on that same edge.
  - In that transition cycle a port A access is still performed if requested. It precedes the clear.
  - clr sampled during CLEAR is ignored; the sequence does not restart.
  - Reset asserted mid-clear aborts the sequence. It restarts from address 0 after release, subject to CLR_ON_RST.
  - The counter is AW+1 bits wide so that DEPTH=2**AW does not wrap early.
- During CLEAR:
  - a_cs and b_cs are ignored: no writes and no reads.
  - a_dout and b_dout hold their last values.
- Port A write (ready=1, a_cs=1, a_we=1):
  - mem[a_adr] byte i is updated only where a_be[i]=1.
  - a_dout holds its value on a write cycle.
- Port A read (ready=1, a_cs=1, a_we=0): a_dout <= mem[a_adr], valid after the sampling edge (1-cycle latency, same as sp1_ram).
- Port B read (ready=1, b_cs=1): b_dout <= mem[b_adr], 1-cycle latency.
- Deselected port (cs=0): dout holds. cs/we/adr/din values of X on a deselected port must not corrupt state.
- Out-of-range address (adr >= DEPTH, possible only when DEPTH < 2**AW):
  - A write is dropped.
  - A read loads 0 into dout.
- Collision (A writes address X and B reads X on the same edge):
  - RDW_MODE=0: b_dout gets the pre-write word.
  - RDW_MODE=1: b_dout gets the merged word (a_din on enabled bytes, old data on the rest).
  - The array is updated identically in both modes.
- Both ports reading the same address simultaneously: both get the same word; no conflict.

Test Plan:
- Reset, CLR_ON_RST=1, DEPTH=64: release rst at cycle 3 -> ready=0 for exactly 64 cycles, then 1; read of every address on A and B returns 00000000.
- Write A adr=05 din=DEADBEEF be=1111; then write adr=05 din=11223344 be=0101 -> read A adr=05 returns DE22BE44 one cycle after the read edge; a_dout unchanged during both write cycles.
- Same edge: A writes adr=0A din=CAFEF00D be=1111 (old 12345678) while B reads 0A -> b_dout=12345678 with RDW_MODE=0, CAFEF00D with RDW_MODE=1; a subsequent B read returns CAFEF00D in both modes.
- Pulse clr in READY with array written -> ready drops on that edge; b_cs=1 and a writes during the 64-cycle clear have no effect; afterwards all words read 0; a second clr pulse at clear cycle 10 does not extend the sequence.
- DEPTH=48, AW=6: write adr=30 (hex) din=FFFFFFFF -> dropped; read adr=30 returns 00000000; read adr=2F is unaffected.
- Assert rst at clear cycle 20, release -> a_dout=b_dout=0 immediately; ready stays 0 for a full 64 cycles from release.
